// File: rtl/repetition_stim_gen.sv
// repetition_stim_gen
//   Drives a single-bit trace that realises one of the three SVA repetition
//   forms: consecutive [*N], goto [->N] or non-consecutive [=N]. One command
//   is accepted at a time. A registered done pulse closes each trace, and err
//   marks a reserved mode or an aborted trace.
//
// Handshake: a command (mode_i, count_i, gap_i) is taken at a posedge where
//   req_i && ready_o. ready_o is high exactly while the FSM sits in IDLE.
//   Inputs are captured on accept, so later changes do not affect the trace.
//
// Ports
//   clk_i     clock, all state updates on posedge
//   rst_ni    asynchronous active-low reset
//   req_i     command valid
//   ready_o   command accepted when req_i && ready_o at posedge
//   mode_i    0 consecutive, 1 goto, 2 non-consecutive, 3 reserved
//   count_i   number of hits N
//   gap_i     low cycles between hits (modes 1/2), trailing low cycles (mode 2)
//   abort_i   synchronous cancel of the running trace
//   a_o       generated trace (registered)
//   busy_o    high from the cycle after accept until done, exclusive
//   done_o    one-cycle end-of-trace pulse (registered)
//   err_o     one-cycle pulse coincident with done_o on reserved mode / abort
//   state_o   current FSM state, for debug and checkers
module repetition_stim_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             ready_o,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             abort_i,
  output logic             a_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HIGH = 3'd1,
    S_GAP  = 3'd2,
    S_TAIL = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             a_q, busy_q, done_q, err_q;
  logic             err_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    hit_d   = hit_q;
    gcnt_d  = gcnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          mode_d = mode_i;
          cnt_d  = count_i;
          gap_d  = gap_i;
          hit_d  = '0;
          gcnt_d = '0;
          if (count_i == '0 || mode_i == 2'd3) begin
            state_d = S_FIN;
            err_d   = (mode_i == 2'd3);
          end else begin
            state_d = S_HIGH;
          end
        end
      end

      S_HIGH: begin
        if (abort_i) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          hit_d  = hit_q + CNT_ONE;
          gcnt_d = '0;
          // Counters stop on equality with the captured value, so they never wrap.
          if (hit_d == cnt_q) begin
            state_d = (mode_q == 2'd2 && gap_q != '0) ? S_TAIL : S_FIN;
          end else if (mode_q == 2'd0 || gap_q == '0) begin
            state_d = S_HIGH;
          end else begin
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (abort_i) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GAP_ONE;
          if (gcnt_d == gap_q) begin
            gcnt_d  = '0;
            state_d = S_HIGH;
          end
        end
      end

      S_TAIL: begin
        if (abort_i) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GAP_ONE;
          if (gcnt_d == gap_q) begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      hit_q   <= '0;
      gcnt_q  <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      hit_q   <= hit_d;
      gcnt_q  <= gcnt_d;
      // Outputs are flops decoded from the next state so they are glitch-free.
      a_q     <= (state_d == S_HIGH);
      busy_q  <= (state_d == S_HIGH) || (state_d == S_GAP) || (state_d == S_TAIL);
      done_q  <= (state_d == S_FIN);
      err_q   <= err_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign a_o     = a_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_repetition_stim_gen.sv
// Directed bench for repetition_stim_gen. Inputs are driven and outputs
// sampled on the falling clock edge; each command's expected trace is a
// hand-written bit vector (bit i = cycle T+1+i after the accepting edge T).
module tb_repetition_stim_gen;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       ready;
  logic [1:0] mode;
  logic [3:0] count;
  logic [3:0] gap;
  logic       abort;
  logic       a;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  // five-in-a-row matcher state
  int m5_run;
  int m5_fires;
  int m5_at;

  logic [255:0] big_exp;

  repetition_stim_gen #(.CNT_W(4), .GAP_W(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .ready_o (ready),
    .mode_i  (mode),
    .count_i (count),
    .gap_i   (gap),
    .abort_i (abort),
    .a_o     (a),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    for (k = 0; k < 300 && ready !== 1'b1; k++) step();
    chk({tag, "_ready_wait"}, {31'd0, ready}, 32'd1);
  endtask

  // Issue one command and check the whole trace plus the idle cycle after it.
  // abort_idx: trace cycle index during which abort is held (-1 for none).
  // hold: keep req high and scramble command inputs while the trace runs.
  task automatic run_cmd(input string tag, input logic [1:0] m, input logic [3:0] n,
                         input logic [3:0] g, input logic [255:0] exp_a, input int len,
                         input logic exp_err, input int abort_idx, input logic hold);
    wait_ready(tag);
    mode  = m;
    count = n;
    gap   = g;
    req   = 1'b1;
    step();
    if (!hold) req = 1'b0;
    m5_run   = 0;
    m5_fires = 0;
    m5_at    = -1;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s_a_%0d", tag, i), {31'd0, a}, {31'd0, exp_a[i]});
      chk($sformatf("%s_done_%0d", tag, i), {31'd0, done}, {31'd0, (i == len - 1)});
      chk($sformatf("%s_err_%0d", tag, i), {31'd0, err}, {31'd0, (i == len - 1) && exp_err});
      chk($sformatf("%s_busy_%0d", tag, i), {31'd0, busy}, {31'd0, (i != len - 1)});
      chk($sformatf("%s_ready_%0d", tag, i), {31'd0, ready}, 32'd0);
      m5_run = (a === 1'b1) ? m5_run + 1 : 0;
      if (m5_run == 5) begin
        m5_fires++;
        m5_at = i;
      end
      if (i == abort_idx) abort = 1'b1;
      if (hold) begin
        mode  = 2'($urandom_range(0, 3));
        count = 4'($urandom_range(0, 15));
        gap   = 4'($urandom_range(0, 15));
      end
      step();
      abort = 1'b0;
    end
    // exactly one idle cycle, ready again, trace quiet
    chk({tag, "_idle_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_idle_a"}, {31'd0, a}, 32'd0);
    chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    mode  = 2'd0;
    count = 4'd0;
    gap   = 4'd0;
    abort = 1'b0;
    big_exp = '0;

    // reset values
    #12;
    chk("rst_a", {31'd0, a}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // mode 0, N=5: a in T+1..T+5, done T+6; matcher fires once at T+5
    run_cmd("m0_n5", 2'd0, 4'd5, 4'd3, 256'b011111, 6, 1'b0, -1, 1'b0);
    chk("m0_n5_m5_fires", m5_fires, 32'd1);
    chk("m0_n5_m5_at", m5_at, 32'd4);

    // mode 1, N=3, gap=2: hits T+1/T+4/T+7, done T+8
    run_cmd("m1_n3_g2", 2'd1, 4'd3, 4'd2, 256'b0100_1001, 8, 1'b0, -1, 1'b0);
    // mode 2, N=3, gap=2: same hits, tail T+8..T+9, done T+10
    run_cmd("m2_n3_g2", 2'd2, 4'd3, 4'd2, 256'b00_0100_1001, 10, 1'b0, -1, 1'b0);
    // gap=0 collapses modes 1/2 to mode 0
    run_cmd("m1_n4_g0", 2'd1, 4'd4, 4'd0, 256'b01111, 5, 1'b0, -1, 1'b0);
    run_cmd("m2_n3_g0", 2'd2, 4'd3, 4'd0, 256'b0111, 4, 1'b0, -1, 1'b0);

    // edge commands
    run_cmd("cnt0", 2'd1, 4'd0, 4'd5, 256'b0, 1, 1'b0, -1, 1'b0);
    run_cmd("mode3", 2'd3, 4'd5, 4'd2, 256'b0, 1, 1'b1, -1, 1'b0);
    // N=15, gap=15, mode 2: hits every 16 cycles from offset 0 to 224,
    // 15-cycle tail, done at offset 240 -> 241 cycles
    for (int h = 0; h < 15; h++) big_exp[h * 16] = 1'b1;
    run_cmd("m2_n15_g15", 2'd2, 4'd15, 4'd15, big_exp, 241, 1'b0, -1, 1'b0);

    // abort in mode 1 during second GAP (cycle T+5, index 4): done/err at T+6
    run_cmd("abort_m1", 2'd1, 4'd3, 4'd2, 256'b00_1001, 6, 1'b1, 4, 1'b0);
    step();
    chk("abort_after_a", {31'd0, a}, 32'd0);
    chk("abort_after_done", {31'd0, done}, 32'd0);

    // abort in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_done", {31'd0, done}, 32'd0);
    chk("abort_idle_err", {31'd0, err}, 32'd0);
    chk("abort_idle_ready", {31'd0, ready}, 32'd1);

    // req held high with alternating commands; inputs scrambled mid-trace
    run_cmd("hold_m0", 2'd0, 4'd2, 4'd7, 256'b011, 3, 1'b0, -1, 1'b1);
    run_cmd("hold_m1", 2'd1, 4'd2, 4'd1, 256'b0101, 4, 1'b0, -1, 1'b1);
    run_cmd("hold_m2", 2'd2, 4'd1, 4'd3, 256'b00001, 5, 1'b0, -1, 1'b1);
    req = 1'b0;
    step();

    // asynchronous reset mid-HIGH
    wait_ready("rst_mid");
    mode  = 2'd0;
    count = 4'd10;
    gap   = 4'd0;
    req   = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("rst_mid_a_before", {31'd0, a}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a", {31'd0, a}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("rst_mid_nodone_%0d", i), {31'd0, done}, 32'd0);
    end
    run_cmd("post_rst", 2'd1, 4'd2, 4'd3, 256'b01_0001, 6, 1'b0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/repetition_stim_gen.md
# repetition_stim_gen

Stimulus generator that drives a single-bit trace `a` matching one of the three SVA repetition forms: consecutive `[*N]`, goto `[->N]` or non-consecutive `[=N]`. It is the transmit side of the repetition examples: it produces the traces that the repetition checkers and covers (e.g. the five-in-a-row matcher) consume. A request/ready handshake accepts one command at a time. A `done` pulse marks the end of each generated trace.

## Interface
- `CNT_W`, default 4: width of `count`; max repetitions 2^CNT_W-1.
- `GAP_W`, default 4: width of `gap`; max idle cycles between hits 2^GAP_W-1.

- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  command valid.
- `ready`  out  1  command accepted when `req && ready` at posedge; equals (state == IDLE).
- `mode`  in  2  0 = consecutive, 1 = goto, 2 = non-consecutive, 3 = reserved.
- `count`  in  CNT_W  number of hits N.
- `gap`  in  GAP_W  low cycles between hits (goto / non-consecutive); also trailing low cycles (non-consecutive).
- `abort`  in  1  synchronous cancel of the running trace.
- `a`  out  1  generated trace, registered.
- `busy`  out  1  high from the cycle after accept until `done`, exclusive.
- `done`  out  1  one-cycle pulse, registered.
- `err`  out  1  one-cycle pulse, coincident with `done`; flags reserved mode or abort.

## Operation
- The command (`mode`, `count`, `gap`) is captured into internal registers on accept. Input changes after accept are ignored.
- States:
  - IDLE: `ready`=1; accept goes to HIGH, or to FIN if `count`=0 or `mode`=3.
  - HIGH: `a`=1 for one cycle per hit; the hit counter increments.
  - GAP: `a`=0 for `gap` cycles.
  - TAIL: non-consecutive only; `a`=0 for `gap` cycles after the last hit.
  - FIN: `done`=1 for one cycle, then IDLE.
- Mode 0: N back-to-back HIGH cycles, then FIN. `gap` is ignored.
- Mode 1: HIGH, then GAP between hits (not after the last hit). The last hit is followed directly by FIN.
- Mode 2: as mode 1, then TAIL, then FIN.
- With `gap`=0, modes 1 and 2 are identical to mode 0; the GAP and TAIL states are skipped.
- `count`=0 with a valid mode: no hits; `done` is asserted the cycle after accept; `err`=0.
- `mode`=3: no hits; `done` and `err` are asserted the cycle after accept.
- `abort` sampled high while not IDLE: the next cycle is FIN with `a`=0, `done`=1, `err`=1. `abort` in IDLE is ignored. `abort` in FIN is ignored.
- `req` during FIN is not accepted (`ready`=0). The earliest new accept is at the posedge that ends the FIN cycle's successor, i.e. one idle cycle between traces.
- Counters are sized CNT_W / GAP_W with no wrap. Termination compares the counter against the captured value (equal ⇒ stop).

## Timing
- Reset (async assert, sync release): state IDLE, `a`=0, `busy`=0, `done`=0, `err`=0, `ready`=1, counters 0.
- Reset mid-trace: outputs return to reset values immediately; no `done` is produced.
- Accept at posedge T ⇒ first `a`=1 in cycle T+1; `busy`=1 from T+1.
- Mode 0, N=5: `a`=1 in cycles T+1..T+5; `done` in T+6.
- Mode 1, N=3, gap=2: `a`=1 in T+1, T+4, T+7; `done` in T+8.
- Mode 2, N=3, gap=2: as mode 1, plus `a`=0 in T+8 and T+9; `done` in T+10.
- General trace lengths (cycles with `busy` or `done` high):
  - mode 0: N+1
  - mode 1: N + (N-1)·gap + 1
  - mode 2: N + N·gap + 1
- Abort sampled at posedge S ⇒ `a`=0 and `done`/`err`=1 in cycle S+1; `ready`=1 in S+2.

## Test plan
- Reset, then mode 0, N=5 ⇒ `a` high exactly 5 consecutive cycles T+1..T+5; `done` at T+6; a downstream five-in-a-row matcher fires once at T+5.
- Mode 1, N=3, gap=2, then mode 2 with the same N and gap ⇒ hits at T+1/T+4/T+7; `done` at T+8 and T+10 respectively; no `err`.
- Edge commands: `count`=0; `mode`=3; N=15 with gap=15 in mode 2 ⇒
  - `count`=0: `done` at T+1 with `err`=0.
  - `mode`=3: `done`+`err` at T+1.
  - N=15, gap=15, mode 2: 241 cycles of trace, no counter wrap.
- Abort in mode 1 during the second GAP ⇒ `a` stays 0; `done`=`err`=1 the next cycle; no further hits.
- `req` held high continuously with alternating commands ⇒ accepts occur only when `ready`=1; exactly one idle cycle after each `done`; later input changes do not alter a running trace.
- `rst_n` asserted asynchronously mid-HIGH ⇒ `a` drops without waiting for a clock edge; no `done`; a new command after release runs normally.
